inst_fetch_buffer: RTL and testbench
====================================

// Module: inst_fetch_buffer
// PURPOSE
//   Dual-issue instruction queue directly downstream of the pipelined ICache.
//   Accepts up to 2 {inst, addr} pairs per cycle from the ICache outputs and presents up to 2
//   oldest entries per cycle to decode. Decouples ICache hit/miss timing from decode back-pressure.
//   Produces full_o, which the fetch stage ORs into its PC-hold / cpu_req_i gating.
// PARAMETERS
//   DEPTH    16   entries; power of 2, >= 4
//   DATA_W   32   instruction width (`InstBus)
//   ADDR_W   32   instruction address width (`InstAddrBus)
// PORTS
//   clk            in   1       clock
//   rst            in   1       reset; asynchronous, active-low
//   flush_i        in   1       branch redirect / exception: discard all entries
//   inst1_valid_i  in   1       slot-1 push valid (ICache inst1_valid_o)
//   inst2_valid_i  in   1       slot-2 push valid (ICache inst2_valid_o)
//   inst1_i        in   DATA_W  slot-1 instruction
//   inst2_i        in   DATA_W  slot-2 instruction
//   inst1_addr_i   in   ADDR_W  slot-1 address
//   inst2_addr_i   in   ADDR_W  slot-2 address
//   full_o         out  1       fewer than 2 free entries; upstream must not push
//   pop_cnt_i      in   2       entries decode consumes this cycle: 0, 1 or 2
//   inst1_o        out  DATA_W  oldest entry instruction
//   inst1_addr_o   out  ADDR_W  oldest entry address
//   inst1_valid_o  out  1       count >= 1
//   inst2_o        out  DATA_W  second-oldest instruction
//   inst2_addr_o   out  ADDR_W  second-oldest address
//   inst2_valid_o  out  1       count >= 2
//   count_o        out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//   - Reset (rst=0, async): head, tail, count = 0; all outputs 0. Storage contents not reset.
//   - Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
//     count is tracked separately; count == DEPTH is legal.
//   - Push: npush = inst1_valid_i + (inst1_valid_i & inst2_valid_i).
//     slot-1 is written at tail; slot-2 is written at tail+1.
//     inst2_valid_i without inst1_valid_i is illegal, is ignored, and is flagged by an assertion.
//     A push while full_o = 1 is dropped; the bench asserts that it never occurs.
//   - Pop: npop = min(pop_cnt_i, count). pop_cnt_i = 3 is treated as 2.
//     Over-pop is clamped and never underflows.
//   - Same cycle: count <= count + npush - npop. A pop frees slots only from the next cycle.
//   - full_o is combinational: (DEPTH - count) < 2. It does not depend on the same-cycle pop.
//   - Latency: a pushed entry is visible at inst1_o/inst2_o the next cycle. There is no bypass.
//   - Empty outputs: inst*_valid_o = 0; inst*_o and inst*_addr_o hold stale storage.
//     Decode must qualify these outputs with the valid flags.
//   - Output order: inst1_o is always older than inst2_o, including across the pointer wrap
//     (head = DEPTH-1 gives inst2 from entry 0).
//   - Flush: highest priority. On the next edge head = tail = count = 0.
//     Same-cycle pushes and pops are discarded.
//   - Reset mid-operation: immediate return to the empty state. full_o = 0 while in reset.
// CONFIGURATION
//   IFB_PERF_CNT_EN defined:
//     - Adds output perf_full_cycles_o (32 bits): a saturating count of cycles with
//       full_o = 1 and inst1_valid_i = 1.
//     - Cleared by reset only, not by flush.
//   IFB_PERF_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//   - Shared package ifb_pkg:
//     - typedef ifb_entry_t {addr[ADDR_W], inst[DATA_W]}
//     - IFB_DEPTH_DEFAULT
//     - ifb_ptr_w() helper
//   - Sub-module ifb_regfile: DEPTH x ifb_entry_t array.
//     - 2 write ports, active on the clk edge.
//     - 2 combinational read ports.
//   - Pointer, count and flush control is local to this module.
// TESTING
//   1. Reset, push {A@0x1000, B@0x1004}, pop 0 -> next cycle count = 2, inst1 = A, inst2 = B, both valid.
//   2. Fill to 14, push 2 -> count = 16, full_o = 1.
//      Pop 2 with no push -> full_o = 1 that cycle, 0 on the next.
//   3. head = 15, count = 2 (entries at 15 and 0) -> inst1_addr_o = entry 15, inst2_addr_o = entry 0.
//      Pop 2 -> head = 1, count = 0.
//   4. count = 1, pop_cnt_i = 2 together with a 2-entry push -> count = 2.
//      The popped entry is gone; inst1 = the first new entry.
//   5. count = 6, flush_i together with a push and pop 1 -> next cycle count = 0, both valid flags 0.
//      A push the cycle after lands at index 0.
//   6. rst asserted mid-stream at count = 9 -> all outputs 0 immediately, without waiting for clk.
//      With IFB_PERF_CNT_EN: 5 cycles of full with a push attempt -> perf_full_cycles_o = 5.

Source files
------------

// File: rtl/ifb_pkg.sv
// ifb_pkg: shared entry type, default depth and pointer-width helper for the instruction fetch buffer.
package ifb_pkg;
    localparam int IFB_DEPTH_DEFAULT = 16;
    localparam int IFB_DATA_W        = 32;
    localparam int IFB_ADDR_W        = 32;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] addr;
        logic [IFB_DATA_W-1:0] inst;
    } ifb_entry_t;

    function automatic int ifb_ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/ifb_regfile.sv
// ifb_regfile: DEPTH x ifb_entry_t storage, two clocked write ports and two combinational read ports.
module ifb_regfile
    import ifb_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH_DEFAULT,
    parameter int PW    = ifb_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we1,
    input  logic [PW-1:0] i_wa1,
    input  ifb_entry_t    i_wd1,
    input  logic          i_we2,
    input  logic [PW-1:0] i_wa2,
    input  ifb_entry_t    i_wd2,
    input  logic [PW-1:0] i_ra1,
    output ifb_entry_t    o_rd1,
    input  logic [PW-1:0] i_ra2,
    output ifb_entry_t    o_rd2
);
    ifb_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we1) r_mem[i_wa1] <= i_wd1;
        if (i_we2) r_mem[i_wa2] <= i_wd2;
    end

    assign o_rd1 = r_mem[i_ra1];
    assign o_rd2 = r_mem[i_ra2];
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: dual-issue instruction queue between the ICache and decode.
// Optional IFB_PERF_CNT_EN adds a saturating count of cycles where a push met full_o.
module inst_fetch_buffer
    import ifb_pkg::*;
#(
    parameter int DEPTH  = IFB_DEPTH_DEFAULT,
    parameter int DATA_W = IFB_DATA_W,
    parameter int ADDR_W = IFB_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   inst1_valid_i,
    input  logic                   inst2_valid_i,
    input  logic [DATA_W-1:0]      inst1_i,
    input  logic [DATA_W-1:0]      inst2_i,
    input  logic [ADDR_W-1:0]      inst1_addr_i,
    input  logic [ADDR_W-1:0]      inst2_addr_i,
    output logic                   full_o,
    input  logic [1:0]             pop_cnt_i,
    output logic [DATA_W-1:0]      inst1_o,
    output logic [ADDR_W-1:0]      inst1_addr_o,
    output logic                   inst1_valid_o,
    output logic [DATA_W-1:0]      inst2_o,
    output logic [ADDR_W-1:0]      inst2_addr_o,
    output logic                   inst2_valid_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef IFB_PERF_CNT_EN
   ,output logic [31:0]            perf_full_cycles_o
`endif
);
    localparam int PW = ifb_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic          w_full, w_push1, w_push2;
    logic [1:0]    w_npush, w_pop_req, w_npop;
    ifb_entry_t    w_rd1, w_rd2;

    assign w_full    = r_count >= CW'(DEPTH - 1);
    assign w_push1   = inst1_valid_i & ~w_full & ~flush_i;
    assign w_push2   = w_push1 & inst2_valid_i;
    assign w_npush   = {1'b0, w_push1} + {1'b0, w_push2};
    assign w_pop_req = pop_cnt_i[1] ? 2'd2 : pop_cnt_i;
    assign w_npop    = (r_count < CW'(w_pop_req)) ? r_count[1:0] : w_pop_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_npop);
            r_tail  <= r_tail + PW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
        end
    end

    ifb_regfile #(.DEPTH(DEPTH), .PW(PW)) u_regfile (
        .clk   (clk),
        .i_we1 (w_push1),
        .i_wa1 (r_tail),
        .i_wd1 ({inst1_addr_i, inst1_i}),
        .i_we2 (w_push2),
        .i_wa2 (r_tail + PW'(1)),
        .i_wd2 ({inst2_addr_i, inst2_i}),
        .i_ra1 (r_head),
        .o_rd1 (w_rd1),
        .i_ra2 (r_head + PW'(1)),
        .o_rd2 (w_rd2)
    );

    // Storage is never reset, so data outputs are forced low only while reset is held.
    assign inst1_o       = rst ? w_rd1.inst : '0;
    assign inst1_addr_o  = rst ? w_rd1.addr : '0;
    assign inst2_o       = rst ? w_rd2.inst : '0;
    assign inst2_addr_o  = rst ? w_rd2.addr : '0;
    assign inst1_valid_o = r_count != '0;
    assign inst2_valid_o = r_count > CW'(1);
    assign count_o       = r_count;
    assign full_o        = w_full;

`ifdef IFB_PERF_CNT_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_perf <= '0;
        else if (w_full && inst1_valid_i && r_perf != '1) r_perf <= r_perf + 32'd1;
    end
    assign perf_full_cycles_o = r_perf;
`endif

    a_no_slot2_alone: assert property (@(posedge clk) disable iff (!rst) !(inst2_valid_i && !inst1_valid_i));
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: queue-model checker for inst_fetch_buffer plus directed literal checks.
module tb_inst_fetch_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b0, flush_i = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [31:0] i1 = '0, i2 = '0, a1 = '0, a2 = '0;
    logic [1:0]  pc = '0;
    logic        full_o, inst1_valid_o, inst2_valid_o;
    logic [31:0] inst1_o, inst1_addr_o, inst2_o, inst2_addr_o;
    logic [4:0]  count_o;
`ifdef IFB_PERF_CNT_EN
    logic [31:0] perf_full_cycles_o;
`endif

    inst_fetch_buffer dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst1_valid_i(v1), .inst2_valid_i(v2),
        .inst1_i(i1), .inst2_i(i2), .inst1_addr_i(a1), .inst2_addr_i(a2),
        .full_o(full_o), .pop_cnt_i(pc),
        .inst1_o(inst1_o), .inst1_addr_o(inst1_addr_o), .inst1_valid_o(inst1_valid_o),
        .inst2_o(inst2_o), .inst2_addr_o(inst2_addr_o), .inst2_valid_o(inst2_valid_o),
        .count_o(count_o)
`ifdef IFB_PERF_CNT_EN
       ,.perf_full_cycles_o(perf_full_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    ent_t        mq[$];
    int          n_chk = 0, n_fail = 0;
    bit          allow_full_push = 1'b0;
    logic [31:0] nxt = 32'h1000;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference queue: pops happen first, pushes are accepted only if the pre-edge occupancy leaves 2 free slots.
    always @(posedge clk or negedge rst) begin : model
        int np;
        bit full;
        if (!rst || flush_i) mq.delete();
        else begin
            full = (DEPTH - mq.size()) < 2;
            np = (pc == 2'd3) ? 2 : int'(pc);
            if (np > mq.size()) np = mq.size();
            repeat (np) void'(mq.pop_front());
            if (v1 && !full) begin
                mq.push_back('{a: a1, i: i1});
                if (v2) mq.push_back('{a: a2, i: i2});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_count", 64'(count_o), 64'd0);
            chk("rst_flags", 64'({inst1_valid_o, inst2_valid_o, full_o}), 64'd0);
            chk("rst_slot1", {inst1_addr_o, inst1_o}, 64'd0);
            chk("rst_slot2", {inst2_addr_o, inst2_o}, 64'd0);
        end else begin
            chk("count", 64'(count_o), 64'(mq.size()));
            chk("full", 64'(full_o), 64'((DEPTH - mq.size()) < 2));
            chk("valid1", 64'(inst1_valid_o), 64'(mq.size() >= 1));
            chk("valid2", 64'(inst2_valid_o), 64'(mq.size() >= 2));
            if (mq.size() >= 1) chk("slot1", {inst1_addr_o, inst1_o}, {mq[0].a, mq[0].i});
            if (mq.size() >= 2) chk("slot2", {inst2_addr_o, inst2_o}, {mq[1].a, mq[1].i});
        end
    end

    task automatic cyc(input bit pv1, input bit pv2, input logic [1:0] ppc, input bit pfl);
        v1 = pv1; v2 = pv2; pc = ppc; flush_i = pfl;
        a1 = nxt; a2 = nxt + 32'd4; i1 = ins(a1); i2 = ins(a2);
        if (pv1) nxt += pv2 ? 32'd8 : 32'd4;
        if (pv1 && !allow_full_push) chk("push_while_full", 64'(full_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("t0_count", 64'(count_o), 64'd0);
        chk("t0_inst1", 64'(inst1_o), 64'd0);
        rst = 1'b1;
        // 1: two pushes visible next cycle, in order
        cyc(1, 1, 0, 0);
        chk("t1_count", 64'(count_o), 64'd2);
        chk("t1_slot1", {inst1_addr_o, inst1_o}, {32'h1000, 32'h1000_0013});
        chk("t1_slot2", {inst2_addr_o, inst2_o}, {32'h1004, 32'h1004_0013});
        chk("t1_valids", 64'({inst1_valid_o, inst2_valid_o}), 64'd3);
        // 2: fill to 16, full; pop does not clear full until the next cycle
        repeat (6) cyc(1, 1, 0, 0);
        chk("t2_count14", 64'(count_o), 64'd14);
        chk("t2_full14", 64'(full_o), 64'd0);
        cyc(1, 1, 0, 0);
        chk("t2_count16", 64'(count_o), 64'd16);
        chk("t2_full16", 64'(full_o), 64'd1);
        v1 = 1'b0; v2 = 1'b0; pc = 2'd2; flush_i = 1'b0;
        #1;
        chk("t2_full_during_pop", 64'(full_o), 64'd1);
        @(posedge clk);
        #1;
        chk("t2_full_after_pop", 64'(full_o), 64'd0);
        chk("t2_count_after_pop", 64'(count_o), 64'd14);
        // 3: head at 15, second entry wraps to index 0
        repeat (6) cyc(0, 0, 2, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("t3_count", 64'(count_o), 64'd2);
        chk("t3_addr1", 64'(inst1_addr_o), 64'h103C);
        chk("t3_addr2", 64'(inst2_addr_o), 64'h1040);
        cyc(0, 0, 2, 0);
        chk("t3_empty", 64'(count_o), 64'd0);
        // 4: over-pop combined with a double push
        cyc(1, 0, 0, 0);
        cyc(1, 1, 2, 0);
        chk("t4_count", 64'(count_o), 64'd2);
        chk("t4_slot1", {inst1_addr_o, inst1_o}, {32'h1048, 32'h1048_0013});
        chk("t4_addr2", 64'(inst2_addr_o), 64'h104C);
        // 5: flush beats push and pop
        repeat (2) cyc(1, 1, 0, 0);
        chk("t5_count6", 64'(count_o), 64'd6);
        cyc(1, 1, 1, 1);
        chk("t5_flush", 64'({count_o, inst1_valid_o, inst2_valid_o}), 64'd0);
        cyc(1, 0, 0, 0);
        chk("t5_after_flush", {27'd0, count_o, inst1_addr_o}, {32'd1, 32'h1068});
        // pop_cnt = 3 behaves as 2 and is clamped at empty
        cyc(1, 1, 0, 0);
        cyc(0, 0, 3, 0);
        chk("pop3_count", 64'(count_o), 64'd1);
        cyc(0, 0, 3, 0);
        chk("pop3_clamp", 64'(count_o), 64'd0);
        // 6: asynchronous reset mid-stream
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t6_count9", 64'(count_o), 64'd9);
        v1 = 1'b0; v2 = 1'b0; pc = 2'd0;
        #1 rst = 1'b0;
        #1;
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_flags", 64'({inst1_valid_o, inst2_valid_o, full_o}), 64'd0);
        chk("t6_slot1", {inst1_addr_o, inst1_o}, 64'd0);
        chk("t6_slot2", {inst2_addr_o, inst2_o}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
`ifdef IFB_PERF_CNT_EN
        repeat (8) cyc(1, 1, 0, 0);
        chk("perf_full", 64'(full_o), 64'd1);
        allow_full_push = 1'b1;
        repeat (5) cyc(1, 0, 0, 0);
        allow_full_push = 1'b0;
        chk("perf_count", 64'(perf_full_cycles_o), 64'd5);
        chk("perf_occupancy", 64'(count_o), 64'd16);
`endif
        cyc(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
